inv_retime_pipe: RTL and testbench
==================================

// Module: inv_retime_pipe
// PURPOSE
//   Parametrised successor to the single-bit inverter+DFF output stage: NCH channels of W bits,
//   selectively inverted, then retimed through a DEPTH-stage elastic pipeline.
//   Adds a valid/ready handshake, back-pressure, flush and occupancy reporting.
//   Sits between a block's raw outputs and the design's primary outputs.
// PARAMETERS
//   NCH       4        number of channels
//   W         8        bits per channel
//   DEPTH     2        pipeline stages, >=1 (latency in cycles)
//   INV_MASK  4'b0101  per-channel invert enable (bit c -> channel c), width NCH
// PORTS
//   clk        in   1          single clock, rising edge
//   rst        in   1          synchronous reset, active-high
//   flush      in   1          synchronous drop of all in-flight data
//   inv_en     in   1          global inversion enable, ANDed with INV_MASK
//   in_valid   in   1          input beat present
//   in_ready   out  1          pipeline accepts input this cycle
//   in_data    in   NCH*W      channel c = in_data[c*W +: W]
//   out_valid  out  1          output beat present (stage DEPTH-1 valid)
//   out_ready  in   1          consumer accepts output
//   out_data   out  NCH*W      registered output of last stage
//   occupancy  out  OCC_W      number of valid stages, OCC_W = clog2(DEPTH+1)
// BEHAVIOUR
//   - Reset (rst=1 at edge): all stage valids 0, all stage data 0; out_valid=0, out_data=0,
//     occupancy=0. rst dominates flush and all other inputs.
//   - Capture transform at stage 0: chan c stored as in_data_c ^ {W{inv_en & INV_MASK[c]}};
//     inv_en sampled in the capture cycle only; in-flight data never re-transformed.
//   - Stage k advance: adv[k] = !v[k] | adv[k+1]; adv[DEPTH] = out_ready.
//     in_ready = adv[0] & !flush (combinational through the chain, no bubbles).
//   - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//   - Data registers load only when their stage advances and receives a valid beat;
//     otherwise hold (out_data stable while out_valid & !out_ready).
//   - Latency: beat accepted at edge n appears with out_valid at edge n+DEPTH-1 (DEPTH=1:
//     visible the cycle after capture). Throughput 1 beat/cycle with out_ready held 1.
//   - Full: all v=1 & out_ready=0 -> in_ready=0, nothing moves.
//     Full & out_ready=1 -> simultaneous in and out; occupancy unchanged.
//   - flush=1: next cycle all v=0, occupancy=0; in_ready=0 in flush cycle; data regs
//     keep contents (not visible, out_valid=0). Output transfer in flush cycle still
//     counts if out_valid & out_ready.
//   - occupancy = popcount(v), registered alongside v; max DEPTH, never wraps.
//   - Order preserved; no beat duplicated or dropped except by flush/rst.
//   - Elaboration error if DEPTH<1, NCH<1, W<1.
// STRUCTURE
//   - Package retime_pkg: function clog2; localparam helpers for OCC_W and bus width NCH*W.
//   - Sub-module pipe_stage (one valid+data register, params DW): ports clk, rst, flush,
//     up_valid, up_data, dn_adv, adv, valid, data. Top instantiates DEPTH of them via
//     generate; inversion XOR and occupancy popcount live in the top.
// TESTING
//   1 Reset: rst=1 two cycles with in_valid=1 -> out_valid=0, out_data=0, occupancy=0.
//   2 Invert/latency: NCH=4,W=8,DEPTH=2,inv_en=1, in_data=32'h11223344 once, out_ready=1
//     -> out_data=32'h11DD33BB, out_valid one cycle, 2 cycles after accept; inv_en=0 -> unchanged.
//   3 Back-pressure: stream 0..9, out_ready=0 -> in_ready drops after 2 accepts, occupancy=2;
//     release -> outputs 0..9 in order, 1/cycle, no gaps or loss.
//   4 Simultaneous: full pipe, in_valid=1, out_ready=1 steady -> occupancy stays 2, in_ready=1.
//   5 Flush: occupancy=2, assert flush 1 cycle -> in_ready=0 that cycle, next cycle
//     out_valid=0, occupancy=0; following beat emerges with normal latency.
//   6 Reset mid-stream: rst during full stalled pipe -> next cycle all outputs 0, no stale beat.

Source files
------------

// File: rtl/retime_pkg.sv
// Shared helpers for the inverting retime pipeline: width arithmetic and defaults.
package retime_pkg;

  // Default geometry of the output stage.
  localparam int DEF_NCH   = 4;
  localparam int DEF_W     = 8;
  localparam int DEF_DEPTH = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Width needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return clog2(depth + 1);
  endfunction

  // Width of the flattened multi-channel data bus.
  function automatic int bus_width(input int nch, input int w);
    return nch * w;
  endfunction

endpackage

// File: rtl/inv_retime_pipe_stage.sv
// One elastic pipeline slot: a valid flag plus a data register.
// The slot advances when it is empty or when the slot downstream advances.
module pipe_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  input  logic          dn_adv,
  output logic          adv,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic          valid_r;
  logic [DW-1:0] data_r;

  // Slot can take a new beat when it holds nothing or its beat leaves this cycle.
  assign adv   = !valid_r | dn_adv;
  assign valid = valid_r;
  assign data  = data_r;

  // Valid tracks the upstream beat on advance; flush empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (adv) begin
      valid_r <= up_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Data loads only with a real incoming beat; it is left untouched by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= {DW{1'b0}};
    end else if (adv && up_valid && !flush) begin
      data_r <= up_data;
    end else begin
      data_r <= data_r;
    end
  end

endmodule

// File: rtl/inv_retime_pipe.sv
// Selectively inverting output stage retimed through a DEPTH-slot elastic
// pipeline with valid/ready handshake, flush and occupancy reporting.
module inv_retime_pipe
  import retime_pkg::*;
#(
  parameter int             NCH      = DEF_NCH,
  parameter int             W        = DEF_W,
  parameter int             DEPTH    = DEF_DEPTH,
  parameter logic [NCH-1:0] INV_MASK = NCH'(4'b0101),
  localparam int            OCC_W    = occ_width(DEPTH),
  localparam int            BW       = bus_width(NCH, W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inv_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BW-1:0]    out_data,
  output logic [OCC_W-1:0] occupancy
);

  if (DEPTH < 1 || NCH < 1 || W < 1) begin : g_bad_params
    $error("inv_retime_pipe: DEPTH, NCH and W must all be at least 1");
  end

  logic [DEPTH:0]   adv_s;
  logic [DEPTH-1:0] up_valid_s;
  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] next_valid_s;
  logic [BW-1:0]    up_data_s  [DEPTH];
  logic [BW-1:0]    stage_data_s [DEPTH];
  logic [BW-1:0]    cap_data_s;
  logic [OCC_W-1:0] occ_next_s;
  logic [OCC_W-1:0] occ_r;

  // The consumer closes the advance chain; input is refused while flushing.
  assign adv_s[DEPTH] = out_ready;
  assign in_ready     = adv_s[0] & !flush;

  // Capture-time inversion: each enabled channel is bitwise inverted once on entry.
  always_comb begin
    cap_data_s = {BW{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      cap_data_s[c*W +: W] = in_data[c*W +: W] ^ {W{inv_en & INV_MASK[c]}};
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_valid_s[k] = in_valid & in_ready;
      assign up_data_s[k]  = cap_data_s;
    end else begin : g_body
      assign up_valid_s[k] = valid_s[k-1];
      assign up_data_s[k]  = stage_data_s[k-1];
    end

    pipe_stage #(
      .DW(BW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (up_valid_s[k]),
      .up_data  (up_data_s[k]),
      .dn_adv   (adv_s[k+1]),
      .adv      (adv_s[k]),
      .valid    (valid_s[k]),
      .data     (stage_data_s[k])
    );
  end

  assign out_valid = valid_s[DEPTH-1];
  assign out_data  = stage_data_s[DEPTH-1];

  // Predict next-cycle slot valids and count them so occupancy updates with the valids.
  always_comb begin
    next_valid_s = {DEPTH{1'b0}};
    occ_next_s   = {OCC_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      if (flush) begin
        next_valid_s[k] = 1'b0;
      end else if (adv_s[k]) begin
        next_valid_s[k] = up_valid_s[k];
      end else begin
        next_valid_s[k] = valid_s[k];
      end
      occ_next_s = occ_next_s + OCC_W'(next_valid_s[k]);
    end
  end

  // Occupancy register, cleared by reset alongside the slot valids.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r <= {OCC_W{1'b0}};
    end else begin
      occ_r <= occ_next_s;
    end
  end

  assign occupancy = occ_r;

endmodule

// File: tb/tb_inv_retime_pipe.sv
// Self-checking bench for inv_retime_pipe (NCH=4, W=8, DEPTH=2, INV_MASK=4'b0101).
// Reference model: ordered list of in-flight beats with their slot position.
module tb_inv_retime_pipe;

  localparam int NCH   = 4;
  localparam int W     = 8;
  localparam int DEPTH = 2;
  localparam logic [NCH-1:0] MASK = 4'b0101;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        inv_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  inv_retime_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .inv_en    (inv_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: beats oldest first, with their slot index 0..DEPTH-1.
  int          pos_q[$];
  logic [31:0] dat_q[$];
  int          plan_q[$];
  logic [31:0] last_final = 32'h0;
  bit          model_init = 1'b0;
  bit          exp_rdy;
  bit          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] xform(input bit ie, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    for (int c = 0; c < NCH; c++)
      if (ie && MASK[c]) r[c*W +: W] = ~d[c*W +: W];
    return r;
  endfunction

  // Where each beat ends up after this edge (-1 = handed to consumer).
  task automatic plan_moves(input bit ordy);
    int ahead;
    plan_q.delete();
    ahead = DEPTH;
    foreach (pos_q[i]) begin
      int p;
      int t;
      p = pos_q[i];
      if (p == DEPTH-1) t = ordy ? -1 : p;
      else if (p + 1 < ahead) t = p + 1;
      else t = p;
      plan_q.push_back(t);
      ahead = (t < 0) ? DEPTH : t;
    end
  endtask

  task automatic step(input bit r, input bit f, input bit ie, input bit iv,
                      input logic [31:0] d, input bit ordy);
    int          npos[$];
    logic [31:0] ndat[$];
    rst = r; flush = f; inv_en = ie; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    plan_moves(ordy);
    exp_rdy = !f;
    foreach (plan_q[i]) if (plan_q[i] == 0) exp_rdy = 1'b0;
    if (model_init) chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    @(posedge clk);
    last_acc = iv && exp_rdy && !r;
    if (r) begin
      pos_q.delete(); dat_q.delete(); last_final = 32'h0;
      model_init = 1'b1;
    end else if (f) begin
      pos_q.delete(); dat_q.delete();
    end else begin
      foreach (plan_q[i]) begin
        if (plan_q[i] >= 0) begin
          npos.push_back(plan_q[i]);
          ndat.push_back(dat_q[i]);
          if (plan_q[i] == DEPTH-1 && pos_q[i] != DEPTH-1) last_final = dat_q[i];
        end
      end
      if (iv && exp_rdy) begin
        npos.push_back(0);
        ndat.push_back(xform(ie, d));
        if (DEPTH == 1) last_final = xform(ie, d);
      end
      pos_q = npos;
      dat_q = ndat;
    end
    @(negedge clk);
    if (model_init) begin
      bit ev;
      ev = 1'b0;
      foreach (pos_q[i]) if (pos_q[i] == DEPTH-1) ev = 1'b1;
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      chk("out_data", out_data, last_final);
      chk("occupancy", {30'b0, occupancy}, pos_q.size());
    end
  endtask

  initial begin
    int idx;
    int nout;
    @(negedge clk);

    // Reset held two cycles with input offered.
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_occ", {30'b0, occupancy}, 32'h0);

    // Inversion and two-cycle latency.
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h11223344, 1'b1);
    chk("inv_not_early", {31'b0, out_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("inv_valid", {31'b0, out_valid}, 32'h1);
    chk("inv_data", out_data, 32'h11DD33BB);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("inv_one_cycle", {31'b0, out_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h11223344, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("noinv_data", out_data, 32'h11223344);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Back-pressure: stream 0..9 into a stalled consumer, then release.
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, idx, 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_accepts", idx, 32'd2);
    chk("bp_occ", {30'b0, occupancy}, 32'd2);
    nout = 0;
    for (int i = 0; i < 30 && nout < 10; i++) begin
      if (out_valid) begin
        chk("bp_order", out_data, nout);
        nout++;
      end
      step(1'b0, 1'b0, 1'b0, idx < 10, idx, 1'b1);
      if (last_acc) idx++;
    end
    chk("bp_count", nout, 32'd10);

    // Full pipe with steady in and out.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'hB0 + i, 1'b1);
      chk("sim_occ", {30'b0, occupancy}, 32'd2);
    end

    // Flush of a full pipe, then a fresh beat with normal latency.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hC0, 1'b0);
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_occ", {30'b0, occupancy}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hC1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("post_flush_data", out_data, 32'hC1);

    // Reset in the middle of a stalled full pipe.
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hD0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hD1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hD2, 1'b0);
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_data", out_data, 32'h0);
    chk("midrst_occ", {30'b0, occupancy}, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) == 0, ($urandom % 25) == 0, $urandom % 2,
           ($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
